shift_left_iterative: RTL and testbench

Multi-cycle 64-bit logical left shifter for the RV64 execute stage; the left-direction counterpart to the combinational arithmetic right shifter. It covers SLL/SLLI and the word forms SLLW/SLLIW. It accepts one operation through a valid/ready handshake, applies one binary shift stage per clock (1, 2, 4, 8, 16, 32), and holds the result on a valid/ready output. It trades a 64-wide combinational shift network for fixed six-cycle latency.

---
 rtl/shift_left_iterative.sv | 104 ++++++++++
 tb/tb_shift_left_iterative.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_iterative.sv
// Multi-cycle 64-bit logical left shifter (SLL/SLLI/SLLW/SLLIW).
// One binary shift stage per clock (1,2,4,8,16,32); fixed six-cycle latency.
//
// state   | meaning
// S_IDLE  | ready for a new operation
// S_SHIFT | applying stage k (k = 0..5), one per clock
// S_DONE  | result held until out_ready
`timescale 1ns/1ps
module shift_left_iterative (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [5:0]  in_shamt,
  input  logic        in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_acc;
  logic [5:0]  r_sh;
  logic        r_word;
  logic [2:0]  r_k;
  logic [63:0] w_stage;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  always_comb begin
    w_stage = r_acc;
    case (r_k)
      3'd0: if (r_sh[0]) w_stage = r_acc << 1;
      3'd1: if (r_sh[1]) w_stage = r_acc << 2;
      3'd2: if (r_sh[2]) w_stage = r_acc << 4;
      3'd3: if (r_sh[3]) w_stage = r_acc << 8;
      3'd4: if (r_sh[4]) w_stage = r_acc << 16;
      3'd5: if (r_sh[5]) w_stage = r_acc << 32;
      default: w_stage = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_k == 3'd5) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word form: bits above 31 are replaced by the sign of the 32-bit result.
  assign out_data = r_word ? {{32{r_acc[31]}}, r_acc[31:0]} : r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= 64'd0;
      r_sh   <= 6'd0;
      r_word <= 1'b0;
      r_k    <= 3'd0;
    end else if (w_accept) begin
      r_acc  <= in_data;
      r_sh   <= in_word ? {1'b0, in_shamt[4:0]} : in_shamt;
      r_word <= in_word;
      r_k    <= 3'd0;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_stage;
      r_k   <= r_k + 3'd1;
    end
  end

endmodule

// File: tb/tb_shift_left_iterative.sv
// Self-checking bench for shift_left_iterative: directed vectors plus a
// cycle-level reference model compared against the DUT on every cycle.
`timescale 1ns/1ps
module tb_shift_left_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic        in_word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  shift_left_iterative dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_sll(input logic [63:0] d, input logic [5:0] s, input logic w);
    logic [31:0] t32;
    if (w) begin
      t32 = d[31:0] << s[4:0];
      return {{32{t32[31]}}, t32};
    end
    return d << s;
  endfunction

  // Reference model: idle -> 6 clocks of work -> done until out_ready.
  bit          m_init  = 0;
  int          m_state = 0;   // 0 idle, 1 working, 2 result ready
  int          m_cnt   = 0;
  logic [63:0] m_res   = '0;
  bit          m_clean = 0;
  int          n_acc   = 0;
  int          n_out   = 0;
  int          dut_out = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init  = 1;
      m_state = 0;
      m_clean = 1;
    end else if (m_init) begin
      case (m_state)
        0: if (in_valid) begin
          m_res   = ref_sll(in_data, in_shamt, in_word);
          m_cnt   = 6;
          m_state = 1;
          m_clean = 0;
          n_acc++;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_state = 2;
        end
        default: if (out_ready) begin
          m_state = 0;
          n_out++;
        end
      endcase
    end
  end

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) dut_out++;

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_in_ready",  {63'd0, in_ready},  {63'd0, m_state == 0});
      chk("cyc_busy",      {63'd0, busy},      {63'd0, m_state != 0});
      chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, m_state == 2});
      if (m_state == 2) chk("cyc_out_data", out_data, m_res);
      else if (m_clean) chk("cyc_out_data_rst", out_data, 64'd0);
    end
  end

  // Leaves the caller at the negedge where out_valid was first seen.
  task automatic run_op(input string nm, input logic [63:0] d, input logic [5:0] s,
                        input logic w, input logic [63:0] exp);
    int  edges;
    bit  got;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_word  = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 0;
    got   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_timeout: got no out_valid expected within 20 cycles", nm);
    end else begin
      chk({nm, "_latency"}, 64'(edges), 64'd6);
      chk(nm, out_data, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_word   = 1'b0;
    out_ready = 1'b1;

    // Model pins
    chk("model_full",  ref_sll(64'h1, 6'd63, 1'b0), 64'h8000_0000_0000_0000);
    chk("model_word",  ref_sll(64'hFFFF_FFFF_0000_0001, 6'd31, 1'b1), 64'hFFFF_FFFF_8000_0000);
    chk("model_word3f", ref_sll(64'hFFFF_FFFF_0000_0001, 6'h3F, 1'b1), 64'hFFFF_FFFF_8000_0000);
    chk("model_small", ref_sll(64'h3, 6'd2, 1'b0), 64'hC);

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_out_data",  out_data,           64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-range and zero shifts
    run_op("full63", 64'h1, 6'd63, 1'b0, 64'h8000_0000_0000_0000);
    @(posedge clk); #1;
    run_op("shamt0", 64'hDEAD_BEEF_0123_4567, 6'd0, 1'b0, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk); #1;

    // Word mode
    run_op("word31", 64'hFFFF_FFFF_0000_0001, 6'd31, 1'b1, 64'hFFFF_FFFF_8000_0000);
    @(posedge clk); #1;
    run_op("word3f", 64'hFFFF_FFFF_0000_0001, 6'h3F, 1'b1, 64'hFFFF_FFFF_8000_0000);
    @(posedge clk); #1;
    run_op("word4", 64'h1, 6'd4, 1'b1, 64'h10);
    @(posedge clk); #1;

    // Backpressure with in_valid pulsed during DONE
    out_ready = 1'b0;
    run_op("bp", 64'h5, 6'd1, 1'b0, 64'hA);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 in_valid = (i % 2 == 0);
      in_data  = 64'h1234_5678_9ABC_DEF0 + 64'(i);
      in_shamt = 6'(i + 3);
      @(negedge clk);
      chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready",   {63'd0, in_ready},  64'd0);
      chk("bp_data_held",  out_data,           64'hA);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_in_ready",  {63'd0, in_ready},  64'd1);
    chk("bp_after_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Reset during the third SHIFT cycle
    in_valid = 1'b1;
    in_data  = 64'hFF;
    in_shamt = 6'd8;
    in_word  = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy",      {63'd0, busy},      64'd0);
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("after_rst", 64'h3, 6'd2, 1'b0, 64'hC);
    @(posedge clk); #1;

    // Random traffic with random stalls
    target = n_acc + 200;
    for (int c = 0; c < 8000 && n_acc < target; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       in_shamt = 6'd0;
        1:       in_shamt = 6'h3F;
        default: in_shamt = 6'($urandom_range(0, 63));
      endcase
      in_word   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && m_state != 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rand_ops_accepted", 64'(n_acc >= target), 64'd1);
    chk("rand_no_drop_dup",  64'(dut_out), 64'(n_out));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
